// File: rtl/vram_text_writer_if.sv
// Byte-stream and VRAM port bundle for the text-console writer.
//   in_data/in_invert/in_valid/in_ready : character stream (valid/ready handshake)
//   ram_we/ram_addr/ram_wdata           : VRAM write/address port
//   ram_rdata                           : VRAM read data, one cycle after ram_addr
// Modports: master = byte source + VRAM side, slave = the writer.
interface vram_text_writer_if #(
  parameter int unsigned AW = 8
);
  logic [7:0]    in_data;
  logic          in_invert;
  logic          in_valid;
  logic          in_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  modport master (
    output in_data, in_invert, in_valid, ram_rdata,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  in_data, in_invert, in_valid, ram_rdata,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_text_writer.sv
// Writer side of the character-layer VRAM: turns an ASCII byte stream into tile words
// ({invert, 7'b0, code}) in the ROWS x COLS tile RAM, with cursor advance, line wrap,
// CR/LF/BS/FF handling and hardware scroll by row copy.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : byte stream in, VRAM read/write port out
//   busy        : ~in_ready
//   cursor_row  : current cursor row
//   cursor_col  : current cursor column
// Option macro VRAM_CURSOR_EN: shows the cursor cell with bit 15 toggled through a
// read-modify-write before and after every accepted byte (4 extra cycles per byte).
module vram_text_writer #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 32,
  parameter logic [7:0]  BLANK_TILE = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  vram_text_writer_if.slave       bus,
  output logic                    busy,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col
);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned AW    = RW + CW;
  localparam int unsigned CELLS = ROWS * COLS;

  localparam logic [RW-1:0] LastRow   = RW'(ROWS - 1);
  localparam logic [CW-1:0] LastCol   = CW'(COLS - 1);
  localparam logic [AW-1:0] LastCopy  = AW'(CELLS - COLS - 1);
  localparam logic [AW-1:0] LastCell  = AW'(CELLS - 1);
  localparam logic [AW-1:0] RowStride = AW'(COLS);
  localparam logic [15:0]   BlankWord = {8'h00, BLANK_TILE};

  localparam logic [7:0] ChBs = 8'h08;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChFf = 8'h0C;
  localparam logic [7:0] ChCr = 8'h0D;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StPut,
    StScrollRd,
    StScrollWr,
    StScrollFill,
    StCurRd,
    StCurWr
  } state_e;

`ifdef VRAM_CURSOR_EN
  // Finished operations go through the cursor re-apply pair before returning to idle.
  localparam state_e DoneSt = StCurRd;
`else
  localparam state_e DoneSt = StIdle;
`endif

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    code_q, code_d;
  logic          inv_q, inv_d;

`ifdef VRAM_CURSOR_EN
  state_e        op_q, op_d;     // operation to run once the cursor has been removed
  logic          phase_q, phase_d; // 0: removing before op, 1: re-applying after op
`endif

  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [15:0]   wdata_c;
  logic          ready_c;
  logic          is_print;
  state_e        target;

  assign is_print = (code_q >= 8'h20) && (code_q <= 8'h7E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      inv_q   <= 1'b0;
`ifdef VRAM_CURSOR_EN
      op_q    <= StIdle;
      phase_q <= 1'b1; // the power-on clear is followed by drawing the cursor
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      inv_q   <= inv_d;
`ifdef VRAM_CURSOR_EN
      op_q    <= op_d;
      phase_q <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    inv_d   = inv_q;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    ready_c = 1'b0;
    target  = StPut;
`ifdef VRAM_CURSOR_EN
    op_d    = op_q;
    phase_d = phase_q;
`endif

    unique case (state_q)
      StClear: begin
        we_c    = 1'b1;
        addr_c  = cnt_q;
        wdata_c = BlankWord;
        cnt_d   = cnt_q + AW'(1);
        row_d   = '0;
        col_d   = '0;
        if (cnt_q == LastCell) state_d = DoneSt;
      end

      StIdle: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          code_d = bus.in_data;
          inv_d  = bus.in_invert;
          if (bus.in_data == ChFf) begin
            target = StClear;
            cnt_d  = '0;
          end else if (bus.in_data == ChLf && row_q == LastRow) begin
            // LF on the last row has nothing to write, so the scroll starts straight away.
            target = StScrollRd;
            cnt_d  = '0;
          end else begin
            target = StPut;
          end
`ifdef VRAM_CURSOR_EN
          state_d = StCurRd;
          op_d    = target;
          phase_d = 1'b0;
`else
          state_d = target;
`endif
        end
      end

      StPut: begin
        state_d = DoneSt;
        if (is_print) begin
          we_c    = 1'b1;
          addr_c  = {row_q, col_q};
          wdata_c = {inv_q, 7'b0, code_q};
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              state_d = StScrollRd;
              cnt_d   = '0;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else if (code_q == ChLf) begin
          col_d = '0;
          if (row_q == LastRow) begin
            state_d = StScrollRd;
            cnt_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else if (code_q == ChCr) begin
          col_d = '0;
        end else if (code_q == ChBs && col_q != '0) begin
          col_d   = col_q - CW'(1);
          we_c    = 1'b1;
          addr_c  = {row_q, col_q - CW'(1)};
          wdata_c = BlankWord;
        end
      end

      StScrollRd: begin
        addr_c  = cnt_q + RowStride;
        state_d = StScrollWr;
      end

      StScrollWr: begin
        // ram_rdata holds the cell one row below, fetched in the previous cycle.
        we_c    = 1'b1;
        addr_c  = cnt_q;
        wdata_c = bus.ram_rdata;
        cnt_d   = cnt_q + AW'(1);
        state_d = (cnt_q == LastCopy) ? StScrollFill : StScrollRd;
      end

      StScrollFill: begin
        we_c    = 1'b1;
        addr_c  = cnt_q;
        wdata_c = BlankWord;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == LastCell) begin
          state_d = DoneSt;
          row_d   = LastRow;
          col_d   = '0;
        end
      end

`ifdef VRAM_CURSOR_EN
      StCurRd: begin
        addr_c  = {row_q, col_q};
        state_d = StCurWr;
      end

      StCurWr: begin
        // XOR makes remove and re-apply the same operation and restores the attribute.
        we_c    = 1'b1;
        addr_c  = {row_q, col_q};
        wdata_c = bus.ram_rdata ^ 16'h8000;
        if (!phase_q) begin
          state_d = op_q;
          phase_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StClear;
    endcase
  end

  // Reset forces the write port quiet at once, even though the reset state is CLEAR.
  assign bus.in_ready  = ready_c & ~rst;
  assign bus.ram_we    = we_c & ~rst;
  assign bus.ram_addr  = rst ? '0 : addr_c;
  assign bus.ram_wdata = rst ? '0 : wdata_c;
  assign busy          = ~bus.in_ready;
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
endmodule
